// File: rtl/cmd_seq_pkg.sv
// rtl/cmd_seq_pkg.sv - state encoding and common response constants for the script sequencer
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_SENT,
        S_WAIT_RESP,
        S_CHECK,
        S_DONE
    } seq_state_t;

    localparam logic [15:0] CMD_NOP  = 16'h0000;
    localparam logic [7:0]  RESP_ACK = 8'hA5;
    localparam logic [7:0]  RESP_NAK = 8'h5A;

endpackage

// File: rtl/seq_timeout_cnt.sv
// rtl/seq_timeout_cnt.sv - saturating wait-phase timer, shared by the send and response waits
module seq_timeout_cnt #(
    parameter int TMO_W      = 24,
    parameter int TMO_CYCLES = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam logic [TMO_W-1:0] LAST = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] cnt;

    // Parks on LAST so an unattended wait never wraps back to a fresh budget.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != LAST)
            cnt <= cnt + 1'b1;
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/cmd_script_sequencer.sv
// rtl/cmd_script_sequencer.sv - plays a loaded command/expected-response script into RemoteComm
module cmd_script_sequencer
    import cmd_seq_pkg::*;
#(
    parameter int DEPTH        = 8,
    parameter int CMD_W        = 16,
    parameter int RESP_W       = 8,
    parameter int TMO_W        = 24,
    parameter int TMO_CYCLES   = 10_000_000,
    parameter int STOP_ON_FAIL = 1,
    localparam int IDX_W       = $clog2(DEPTH),
    localparam int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [CMD_W-1:0]  ld_cmd,
    input  logic [RESP_W-1:0] ld_exp,
    input  logic              ld_chk,
    input  logic [CNT_W-1:0]  num_cmds,
    input  logic              start,
    input  logic              abort,
    output logic [CMD_W-1:0]  cmd,
    output logic              send_cmd,
    input  logic              cmd_sent,
    input  logic              resp_rdy,
    input  logic [RESP_W-1:0] resp,
    output logic              clr_rx_rdy,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [IDX_W-1:0]  fail_idx,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CMD_W-1:0]  mem_cmd [DEPTH];
    logic [RESP_W-1:0] mem_exp [DEPTH];
    logic              mem_chk [DEPTH];

    seq_state_t        state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  n;
    logic [RESP_W-1:0] resp_q;
    logic              tmo_hit;

    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_expired;
    logic [CNT_W-1:0]  n_sel;
    logic              last_entry;
    logic              step_fail;

    // Script storage survives reset so a harness can replay after a reset.
    always_ff @(posedge clk) begin
        if (ld_en && !abort && state == S_IDLE) begin
            mem_cmd[ld_addr] <= ld_cmd;
            mem_exp[ld_addr] <= ld_exp;
            mem_chk[ld_addr] <= ld_chk;
        end
    end

    assign tmr_clr    = (state == S_ISSUE) || (state == S_WAIT_SENT && cmd_sent);
    assign tmr_en     = (state == S_WAIT_SENT) || (state == S_WAIT_RESP);
    assign n_sel      = (num_cmds > DEPTH_C) ? DEPTH_C : num_cmds;
    assign last_entry = (CNT_W'(idx) + CNT_W'(1)) == n;
    assign step_fail  = tmo_hit || (mem_chk[idx] && resp_q != mem_exp[idx]);

    seq_timeout_cnt #(
        .TMO_W      (TMO_W),
        .TMO_CYCLES (TMO_CYCLES)
    ) u_tmr (
        .clk     (clk),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            n          <= '0;
            resp_q     <= '0;
            tmo_hit    <= 1'b0;
            cmd        <= '0;
            send_cmd   <= 1'b0;
            clr_rx_rdy <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            fail_idx   <= '0;
            pass_cnt   <= '0;
            fail_cnt   <= '0;
        end else begin
            send_cmd   <= 1'b0;
            clr_rx_rdy <= 1'b0;
            done       <= 1'b0;
            if (abort) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                pass  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            n        <= n_sel;
                            idx      <= '0;
                            pass_cnt <= '0;
                            fail_cnt <= '0;
                            pass     <= 1'b0;
                            timeout  <= 1'b0;
                            fail_idx <= '0;
                            busy     <= 1'b1;
                            state    <= (n_sel == '0) ? S_DONE : S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        cmd      <= mem_cmd[idx];
                        send_cmd <= 1'b1;
                        tmo_hit  <= 1'b0;
                        state    <= S_WAIT_SENT;
                    end
                    S_WAIT_SENT: begin
                        if (cmd_sent) begin
                            state <= S_WAIT_RESP;
                        end else if (tmr_expired) begin
                            tmo_hit <= 1'b1;
                            state   <= S_CHECK;
                        end
                    end
                    S_WAIT_RESP: begin
                        // A response arriving on the expiry clock still counts.
                        if (resp_rdy) begin
                            resp_q     <= resp;
                            clr_rx_rdy <= 1'b1;
                            state      <= S_CHECK;
                        end else if (tmr_expired) begin
                            tmo_hit <= 1'b1;
                            state   <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (step_fail) begin
                            if (fail_cnt != DEPTH_C)
                                fail_cnt <= fail_cnt + 1'b1;
                            if (tmo_hit)
                                timeout <= 1'b1;
                            if (fail_cnt == '0)
                                fail_idx <= idx;
                        end else if (pass_cnt != DEPTH_C) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                        if (last_entry || (step_fail && STOP_ON_FAIL != 0)) begin
                            state <= S_DONE;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                    S_DONE: begin
                        done  <= 1'b1;
                        pass  <= (fail_cnt == '0);
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_script_sequencer.sv
// tb/tb_cmd_script_sequencer.sv - directed self-checking bench for cmd_script_sequencer
module tb_cmd_script_sequencer;
    import cmd_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic [2:0]  ld_addr = '0;
    logic [15:0] ld_cmd = '0;
    logic [7:0]  ld_exp = '0;
    logic        ld_chk = 1'b0;
    logic [3:0]  num_cmds = '0;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic        abort = 1'b0;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    logic [15:0] cmd0, cmd1;
    logic        send0, send1, clr0, clr1, busy0, busy1, done0, done1;
    logic        pass0, pass1, tmo0, tmo1;
    logic [2:0]  fidx0, fidx1;
    logic [3:0]  pcnt0, pcnt1, fcnt0, fcnt1;

    int          checks = 0;
    int          failures = 0;
    int          sends[2] = '{0, 0};
    logic [15:0] cmd_log[8];
    logic [7:0]  rsp_tab[8];
    bit          mute = 1'b0;

    always #5 clk = ~clk;

    cmd_script_sequencer #(.DEPTH(8), .TMO_CYCLES(100), .STOP_ON_FAIL(1)) dut (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_cmd(ld_cmd),
        .ld_exp(ld_exp), .ld_chk(ld_chk), .num_cmds(num_cmds), .start(start0),
        .abort(abort), .cmd(cmd0), .send_cmd(send0), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp), .clr_rx_rdy(clr0), .busy(busy0),
        .done(done0), .pass(pass0), .timeout(tmo0), .fail_idx(fidx0),
        .pass_cnt(pcnt0), .fail_cnt(fcnt0)
    );

    cmd_script_sequencer #(.DEPTH(8), .TMO_CYCLES(100), .STOP_ON_FAIL(0)) dut_nostop (
        .clk(clk), .rst(rst), .ld_en(ld_en), .ld_addr(ld_addr), .ld_cmd(ld_cmd),
        .ld_exp(ld_exp), .ld_chk(ld_chk), .num_cmds(num_cmds), .start(start1),
        .abort(abort), .cmd(cmd1), .send_cmd(send1), .cmd_sent(cmd_sent),
        .resp_rdy(resp_rdy), .resp(resp), .clr_rx_rdy(clr1), .busy(busy1),
        .done(done1), .pass(pass1), .timeout(tmo1), .fail_idx(fidx1),
        .pass_cnt(pcnt1), .fail_cnt(fcnt1)
    );

    // RemoteComm model: only one sequencer runs at a time, so both share it.
    initial begin
        int k;
        int step;
        step = 0;
        cmd_sent = 1'b0;
        resp_rdy = 1'b0;
        resp = '0;
        forever begin
            @(posedge clk); #1;
            if (start0 || start1) step = 0;
            if (send0 || send1) begin
                k = send1 ? 1 : 0;
                sends[k]++;
                if (step < 8) cmd_log[step] = k ? cmd1 : cmd0;
                cmd_sent = 1'b1;
                @(posedge clk); #1;
                cmd_sent = 1'b0;
                if (!mute) begin
                    repeat (2) @(posedge clk);
                    #1;
                    resp = rsp_tab[step[2:0]];
                    resp_rdy = 1'b1;
                    for (int c = 0; c < 50; c++) begin
                        @(posedge clk); #1;
                        if (clr0 || clr1) break;
                    end
                    resp_rdy = 1'b0;
                end
                step++;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic load(input int a, input logic [15:0] c, input logic [7:0] e, input logic k);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a[2:0]; ld_cmd = c; ld_exp = e; ld_chk = k;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic pulse_start(input int k, input logic [3:0] num);
        num_cmds = num;
        @(negedge clk);
        if (k == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0; start1 = 1'b0;
    endtask

    task automatic wait_done(input int k, output bit got);
        got = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if ((k == 0) ? done0 : done1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic run(input int k, input logic [3:0] num, output int nsend, output bit got);
        int base;
        base = sends[k];
        pulse_start(k, num);
        wait_done(k, got);
        nsend = sends[k] - base;
    endtask

    initial begin
        int  ns;
        int  base;
        int  n;
        bit  got;
        bit  seen;

        // reset state
        repeat (2) @(negedge clk);
        check_eq("rst_busy", busy0, 0);
        check_eq("rst_send", send0, 0);
        check_eq("rst_done", done0, 0);
        check_eq("rst_cmd", cmd0, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: two-entry passing script, start-to-send latency
        load(0, 16'h2000, RESP_ACK, 1'b1);
        load(1, 16'h4101, RESP_ACK, 1'b1);
        rsp_tab[0] = RESP_ACK; rsp_tab[1] = RESP_ACK;
        base = sends[0];
        pulse_start(0, 4'd2);
        check_eq("t1_send_early", send0, 0);
        check_eq("t1_busy", busy0, 1);
        @(negedge clk);
        check_eq("t1_send_lat", send0, 1);
        check_eq("t1_cmd0", cmd0, 16'h2000);
        wait_done(0, got);
        check_eq("t1_done", got, 1);
        check_eq("t1_sends", sends[0] - base, 2);
        check_eq("t1_cmd1", cmd_log[1], 16'h4101);
        check_eq("t1_pass", pass0, 1);
        check_eq("t1_pass_cnt", pcnt0, 2);
        check_eq("t1_fail_cnt", fcnt0, 0);
        check_eq("t1_busy_end", busy0, 0);
        @(posedge clk); #1;
        check_eq("t1_done_1clk", done0, 0);

        // 2: mismatch on entry 1 stops the script
        load(2, 16'h4202, RESP_ACK, 1'b1);
        rsp_tab[0] = RESP_ACK; rsp_tab[1] = RESP_NAK; rsp_tab[2] = RESP_ACK;
        run(0, 4'd3, ns, got);
        check_eq("t2_done", got, 1);
        check_eq("t2_sends", ns, 2);
        check_eq("t2_fail_idx", fidx0, 1);
        check_eq("t2_pass_cnt", pcnt0, 1);
        check_eq("t2_fail_cnt", fcnt0, 1);
        check_eq("t2_pass", pass0, 0);
        check_eq("t2_timeout", tmo0, 0);

        // 3: silent responder, 100-clock response timeout
        mute = 1'b1;
        pulse_start(0, 4'd1);
        got = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (send0) begin got = 1'b1; break; end
        end
        check_eq("t3_send", got, 1);
        n = 0;
        while (!done0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        check_eq("t3_tmo_lat", n, 103);
        check_eq("t3_timeout", tmo0, 1);
        check_eq("t3_fail_cnt", fcnt0, 1);
        check_eq("t3_pass_cnt", pcnt0, 0);
        mute = 1'b0;

        // 4: run-all mode with an unchecked entry
        load(0, 16'h1000, RESP_ACK, 1'b0);
        load(1, 16'h1101, RESP_ACK, 1'b1);
        load(2, 16'h1202, RESP_ACK, 1'b1);
        rsp_tab[0] = 8'h00; rsp_tab[1] = RESP_NAK; rsp_tab[2] = RESP_ACK;
        run(1, 4'd3, ns, got);
        check_eq("t4_done", got, 1);
        check_eq("t4_sends", ns, 3);
        check_eq("t4_cmd2", cmd_log[2], 16'h1202);
        check_eq("t4_pass_cnt", pcnt1, 2);
        check_eq("t4_fail_cnt", fcnt1, 1);
        check_eq("t4_fail_idx", fidx1, 1);
        check_eq("t4_pass", pass1, 0);

        // 5a: empty script
        base = sends[0];
        pulse_start(0, 4'd0);
        check_eq("t5_done_early", done0, 0);
        @(negedge clk);
        check_eq("t5_done", done0, 1);
        check_eq("t5_pass", pass0, 1);
        check_eq("t5_no_send", sends[0] - base, 0);

        // 5b: num_cmds beyond DEPTH is clamped
        for (int i = 0; i < 8; i++) begin
            load(i, 16'h3000 + 16'(i), RESP_ACK, 1'b1);
            rsp_tab[i] = RESP_ACK;
        end
        run(0, 4'd9, ns, got);
        check_eq("t5_clamp_done", got, 1);
        check_eq("t5_clamp_sends", ns, 8);
        check_eq("t5_clamp_pass_cnt", pcnt0, 8);
        check_eq("t5_clamp_cmd7", cmd_log[7], 16'h3007);

        // 6: abort in WAIT_RESP, then reset mid-script, then replay
        mute = 1'b1;
        pulse_start(0, 4'd8);
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("t6_abort_busy", busy0, 0);
        check_eq("t6_abort_pass", pass0, 0);
        seen = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            if (done0) seen = 1'b1;
        end
        check_eq("t6_no_done", seen, 0);
        mute = 1'b0;
        base = sends[0];
        pulse_start(0, 4'd8);
        for (int c = 0; c < 400 && sends[0] - base < 3; c++) @(negedge clk);
        check_eq("t6_progress", pcnt0 >= 2, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("t6_rst_busy", busy0, 0);
        check_eq("t6_rst_cmd", cmd0, 0);
        check_eq("t6_rst_pass_cnt", pcnt0, 0);
        check_eq("t6_rst_done", done0, 0);
        check_eq("t6_rst_clr", clr0, 0);
        repeat (80) @(negedge clk);
        run(0, 4'd8, ns, got);
        check_eq("t6_replay_done", got, 1);
        check_eq("t6_replay_sends", ns, 8);
        check_eq("t6_replay_pass", pass0, 1);
        check_eq("t6_replay_cmd5", cmd_log[5], 16'h3005);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
